// File: rtl/pingpong_match_ctrl_if.sv
// pingpong_match_ctrl_if: paddle, frame and rally signals between the rally side (master)
// and the match controller (slave).
interface pingpong_match_ctrl_if #(parameter int SCORE_W = 2);
  logic btn_left, btn_right, frame_done, point_left, point_right;
  logic [3:0] pp_led;
  logic step, left_hit, right_hit, serve_side, game_over, winner_right, err;
  logic [SCORE_W-1:0] score_left, score_right;
  modport master (
    output btn_left, btn_right, frame_done, pp_led, point_left, point_right,
    input  step, left_hit, right_hit, score_left, score_right, serve_side, game_over, winner_right, err
  );
  modport slave (
    input  btn_left, btn_right, frame_done, pp_led, point_left, point_right,
    output step, left_hit, right_hit, score_left, score_right, serve_side, game_over, winner_right, err
  );
endinterface

// File: rtl/pingpong_match_ctrl.sv
// pingpong_match_ctrl: match sequencer for the LED ping-pong rally FSM (step pacing, hit windows,
// serve, score, pause, game over). Define PINGPONG_AUTO_SERVE_EN to enable the serve timeout.
module pingpong_match_ctrl #(
  parameter int CNT_W         = 8,
  parameter int STEP_INIT     = 30,
  parameter int STEP_MIN      = 6,
  parameter int SPEEDUP       = 2,
  parameter int PAUSE_FRAMES  = 60,
  parameter int SCORE_W       = 2,
  parameter int POINTS_TO_WIN = 3,
  parameter int SERVE_TIMEOUT = 120
) (
  input logic clk,
  input logic rstn,
  pingpong_match_ctrl_if.slave bus
);
  typedef enum logic [1:0] {SERVE, RALLY, PAUSE, OVER} state_t;
  state_t state;
  logic [1:0] sync_l, sync_r;
  logic prev_l, prev_r, press_l, press_r;
  logic pend_l, pend_r, srv_pend, auto_fire;
  logic step, err, serve_side, winner_right;
  logic [CNT_W-1:0] frame_cnt, period;
  logic [SCORE_W-1:0] score_left, score_right, next_l, next_r;
  logic unused_led;

  if (POINTS_TO_WIN >= (1 << SCORE_W) || SERVE_TIMEOUT < 1) begin : g_bad_cfg
    $error("pingpong_match_ctrl: invalid parameter set");
  end

  assign press_l  = sync_l[1] & ~prev_l;
  assign press_r  = sync_r[1] & ~prev_r;
  assign srv_pend = serve_side ? pend_r : pend_l;
  assign next_l   = score_left + 1'b1;
  assign next_r   = score_right + 1'b1;
  assign unused_led = &{1'b0, bus.pp_led[2:1]};

`ifdef PINGPONG_AUTO_SERVE_EN
  localparam int SW = $clog2(SERVE_TIMEOUT + 1);
  logic [SW-1:0] serve_cnt;
  assign auto_fire = state == SERVE && !srv_pend && bus.frame_done && serve_cnt == SW'(SERVE_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) serve_cnt <= '0;
    else if (state != SERVE || srv_pend || auto_fire) serve_cnt <= '0;
    else if (bus.frame_done) serve_cnt <= serve_cnt + 1'b1;
`else
  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state        <= SERVE;
      sync_l       <= '0;
      sync_r       <= '0;
      prev_l       <= 1'b0;
      prev_r       <= 1'b0;
      pend_l       <= 1'b0;
      pend_r       <= 1'b0;
      step         <= 1'b0;
      err          <= 1'b0;
      serve_side   <= 1'b0;
      winner_right <= 1'b0;
      frame_cnt    <= '0;
      period       <= CNT_W'(STEP_INIT);
      score_left   <= '0;
      score_right  <= '0;
    end else begin
      sync_l <= {sync_l[0], bus.btn_left};
      sync_r <= {sync_r[0], bus.btn_right};
      prev_l <= sync_l[1];
      prev_r <= sync_r[1];
      step   <= 1'b0;
      if (step) begin
        pend_l <= 1'b0;
        pend_r <= 1'b0;
      end
      if (bus.point_left && bus.point_right) err <= 1'b1;
      else if ((bus.point_left || bus.point_right) && state != OVER) begin
        // stale hit requests must not leak into the next serve
        if (bus.point_left) score_left <= next_l;
        else score_right <= next_r;
        serve_side   <= bus.point_left;
        winner_right <= bus.point_right;
        period       <= CNT_W'(STEP_INIT);
        frame_cnt    <= '0;
        pend_l       <= 1'b0;
        pend_r       <= 1'b0;
        state        <= (bus.point_left ? next_l : next_r) == SCORE_W'(POINTS_TO_WIN) ? OVER : PAUSE;
      end else
        case (state)
          SERVE: begin
            if (!serve_side && (press_l || auto_fire)) pend_l <= 1'b1;
            if (serve_side && (press_r || auto_fire)) pend_r <= 1'b1;
            if (srv_pend && bus.frame_done) begin
              step      <= 1'b1;
              state     <= RALLY;
              frame_cnt <= '0;
              period    <= CNT_W'(STEP_INIT);
            end
          end
          RALLY: begin
            if (press_l && bus.pp_led[3]) pend_l <= 1'b1;
            if (press_r && bus.pp_led[0]) pend_r <= 1'b1;
            if (bus.frame_done) begin
              if (frame_cnt == period - CNT_W'(1)) begin
                frame_cnt <= '0;
                step      <= 1'b1;
                if (pend_l || pend_r)
                  period <= period > CNT_W'(STEP_MIN + SPEEDUP) ? period - CNT_W'(SPEEDUP) : CNT_W'(STEP_MIN);
              end else frame_cnt <= frame_cnt + 1'b1;
            end
          end
          PAUSE: begin
            if (bus.frame_done) begin
              frame_cnt <= frame_cnt == CNT_W'(PAUSE_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
              if (frame_cnt == CNT_W'(PAUSE_FRAMES - 1)) state <= SERVE;
            end
          end
          default: begin
            if (press_l || press_r) begin
              score_left  <= '0;
              score_right <= '0;
              err         <= 1'b0;
              state       <= SERVE;
            end
          end
        endcase
    end

  assign bus.step         = step;
  assign bus.left_hit     = pend_l;
  assign bus.right_hit    = pend_r;
  assign bus.score_left   = score_left;
  assign bus.score_right  = score_right;
  assign bus.serve_side   = serve_side;
  assign bus.game_over    = state == OVER;
  assign bus.winner_right = winner_right;
  assign bus.err          = err;
endmodule

// File: tb/tb_pingpong_match_ctrl.sv
// tb_pingpong_match_ctrl: directed match sequence; expected step frames are queued when
// stimulus is driven and matched against each observed step pulse.
module tb_pingpong_match_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pingpong_match_ctrl_if #(.SCORE_W(2)) bus();
  pingpong_match_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int fidx = 0;
  int per;
  int exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.frame_done = 1'b1;
      fidx++;
      cyc();
      bus.frame_done = 1'b0;
      cyc(2);
    end
  endtask

  task automatic press(input logic l, input logic r);
    bus.btn_left = l;
    bus.btn_right = r;
    cyc(4);
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    cyc(3);
  endtask

  task automatic point(input logic l, input logic r);
    bus.point_left = l;
    bus.point_right = r;
    cyc();
    bus.point_left = 1'b0;
    bus.point_right = 1'b0;
    cyc();
  endtask

  task automatic serve_step();
    exp_q.push_back(fidx + 1);
    frames(1);
  endtask

  always @(negedge clk)
    if (rstn && bus.step) begin
      if (exp_q.size() == 0) chk("unexpected_step", fidx, -1);
      else chk("step_frame", fidx, exp_q.pop_front());
    end

  initial begin
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.frame_done = 1'b0;
    bus.point_left = 1'b0;
    bus.point_right = 1'b0;
    bus.pp_led = 4'b0000;
    cyc(3);
    chk("rst_step", bus.step, 0);
    chk("rst_hits", {bus.left_hit, bus.right_hit}, 0);
    chk("rst_scores", {bus.score_left, bus.score_right}, 0);
    chk("rst_flags", {bus.serve_side, bus.game_over, bus.winner_right, bus.err}, 0);
    rstn = 1'b1;
    cyc(2);

    press(1'b0, 1'b1);
    chk("nonserver_ignored", bus.right_hit, 0);
    frames(3);
    press(1'b1, 1'b1);
    chk("serve_left_hit", bus.left_hit, 1);
    chk("serve_right_blocked", bus.right_hit, 0);
    bus.pp_led = 4'b1000;
    serve_step();
    chk("serve_hit_clear", bus.left_hit, 0);

    per = 30;
    exp_q.push_back(fidx + per);
    frames(per);
    for (int i = 0; i < 14; i++) begin
      bus.pp_led = i[0] ? 4'b0001 : 4'b1000;
      press(!i[0], i[0]);
      chk(i[0] ? "right_hit_set" : "left_hit_set", i[0] ? bus.right_hit : bus.left_hit, 1);
      exp_q.push_back(fidx + per);
      frames(per);
      chk("hit_clear", bus.left_hit | bus.right_hit, 0);
      per = (per - 2 < 6) ? 6 : per - 2;
    end

    bus.pp_led = 4'b0100;
    press(1'b0, 1'b1);
    chk("out_of_window_discard", bus.right_hit, 0);
    exp_q.push_back(fidx + per);
    frames(per);

    point(1'b1, 1'b0);
    chk("point1_score", bus.score_left, 1);
    chk("point1_serve_side", bus.serve_side, 1);
    frames(59);
    press(1'b0, 1'b1);
    chk("pause_press_ignored", bus.right_hit, 0);
    frames(1);
    press(1'b0, 1'b1);
    chk("serve_right_hit", bus.right_hit, 1);
    bus.pp_led = 4'b0001;
    serve_step();

    point(1'b1, 1'b1);
    chk("double_point_err", bus.err, 1);
    chk("double_point_scores", {bus.score_left, bus.score_right}, 4);
    point(1'b1, 1'b0);
    chk("point2_score", bus.score_left, 2);
    chk("point2_not_over", bus.game_over, 0);
    point(1'b1, 1'b0);
    chk("point3_score", bus.score_left, 3);
    chk("game_over", bus.game_over, 1);
    chk("winner_left", bus.winner_right, 0);
    frames(3);
    press(1'b1, 1'b0);
    chk("over_scores_cleared", {bus.score_left, bus.score_right}, 0);
    chk("over_err_cleared", bus.err, 0);
    chk("over_left", bus.game_over, 0);
    chk("serve_side_kept", bus.serve_side, 1);

    press(1'b0, 1'b1);
    serve_step();
    point(1'b1, 1'b1);
    chk("err_again", bus.err, 1);
    press(1'b0, 1'b1);
    chk("rally_right_hit", bus.right_hit, 1);
    #3;
    rstn = 1'b0;
    #1;
    chk("async_rst_hit", bus.right_hit, 0);
    chk("async_rst_err", bus.err, 0);
    chk("async_rst_serve_side", bus.serve_side, 0);
    chk("async_rst_step", bus.step, 0);
    cyc(2);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
